// File: rtl/decode_ctrl_stage_pkg.sv
// Shared types and constants for the RV32 decode/control stage.
//  - opcode and funct7 encodings recognised by the decoder
//  - immediate-select and writeback-select encodings
//  - ctrl_bundle_t: the full control bundle handed to execute
//  - md_state_t: mul/div sequencing states
package decode_ctrl_stage_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {IM_NONE = 2'b00, IM_I = 2'b01, IM_S = 2'b10, IM_U = 2'b11} im_sel_e;
   typedef enum logic [1:0] {WR_ALU = 2'b00, WR_MEM = 2'b01, WR_CSR = 2'b10, WR_LINK = 2'b11} wr_sel_e;
   typedef enum logic {IDLE = 1'b0, MD_WAIT = 1'b1} md_state_t;

   typedef struct packed {
      logic       jump;
      logic       jal;
      logic       branch;
      logic       alusrc1;
      logic       alusrc2;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       csr;
      logic       fence;
      logic       muldiv;
      logic       illegal;
      im_sel_e    im_sel;
      wr_sel_e    wr_sel;
      logic [3:0] aluop;
      logic [2:0] md_op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ctrl_bundle_t;

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Handshake and control-bundle bus of the decode/control stage.
//  master: fetch/execute side (drives in_valid, in_instr, flush, out_ready)
//  slave : the decode stage (drives in_ready, out_valid, the bundle and busy)
interface decode_ctrl_stage_if #(
   parameter int ALUOP_W = 4
) ();
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_instr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic               out_jump;
   logic               out_jal;
   logic               out_branch;
   logic               out_alusrc1;
   logic               out_alusrc2;
   logic               out_regwrite;
   logic               out_memread;
   logic               out_memwrite;
   logic               out_csr;
   logic               out_fence;
   logic               out_muldiv;
   logic               out_illegal;
   logic [1:0]         out_im_sel;
   logic [1:0]         out_wr_sel;
   logic [ALUOP_W-1:0] out_aluop;
   logic [2:0]         out_md_op;
   logic [4:0]         out_rd;
   logic [4:0]         out_rs1;
   logic [4:0]         out_rs2;
   logic               busy;

   modport master (
      output in_valid, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_jump, out_jal, out_branch, out_alusrc1, out_alusrc2,
             out_regwrite, out_memread, out_memwrite, out_csr, out_fence, out_muldiv,
             out_illegal, out_im_sel, out_wr_sel, out_aluop, out_md_op, out_rd, out_rs1,
             out_rs2, busy
   );

   modport slave (
      input  in_valid, in_instr, flush, out_ready,
      output in_ready, out_valid, out_jump, out_jal, out_branch, out_alusrc1, out_alusrc2,
             out_regwrite, out_memread, out_memwrite, out_csr, out_fence, out_muldiv,
             out_illegal, out_im_sel, out_wr_sel, out_aluop, out_md_op, out_rd, out_rs1,
             out_rs2, busy
   );
endinterface

// File: rtl/decode_ctrl_stage_decode.sv
// decode_comb: purely combinational RV32 instruction -> ctrl_bundle_t decoder.
//  instr : 32-bit instruction word
//  ctrl  : decoded control bundle including register fields
//  EN_M / EN_CSR select whether RV32M and SYSTEM/CSR are decoded or flagged illegal.
module decode_comb
   import decode_ctrl_stage_pkg::*;
#(
   parameter bit EN_M   = 1'b1,
   parameter bit EN_CSR = 1'b1
) (
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl
);
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_j, is_b, is_u, is_load, is_s, is_r, is_i, is_csr, is_fence;
   logic       known, f7_ok, m_op, ill, ld_unsigned;
   logic       al3, al2, al1, al0;

   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign f7 = instr[31:25];

   // Class decode; every class pattern already requires opcode[1:0] == 11.
   assign is_j     = (op[6:4] == 3'b110) && (op[2:0] == 3'b111);
   assign is_b     = (op == OP_BRANCH);
   assign is_u     = !op[6] && (op[4:0] == 5'b10111);
   assign is_load  = (op == OP_LOAD);
   assign is_s     = (op == OP_STORE);
   assign is_r     = (op == OP_REG);
   assign is_i     = (op == OP_IMM);
   assign is_csr   = (op == OP_SYSTEM);
   assign is_fence = (op == OP_FENCE);

   assign known = is_j | is_b | is_u | is_load | is_s | is_r | is_i | is_csr | is_fence;
   assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
   assign m_op  = is_r && (f7 == F7_MULDIV);
   assign ill   = !known || (is_r && !f7_ok) || (m_op && !EN_M) || (is_csr && !EN_CSR);

   assign ld_unsigned = is_load && (f3[2:1] == 2'b10);
   assign al3 = f7[5] & (is_r | (is_i && (f3 == 3'b101)));
   assign al2 = ((is_i | is_r) & f3[2]) | is_csr;
   assign al1 = ((is_i | is_r | is_csr) & f3[1]) | (is_b & f3[2]) | ld_unsigned;
   assign al0 = ((is_i | is_r | is_csr) & f3[0]) | (is_b & f3[1]) | ld_unsigned;

   always_comb begin
      ctrl          = '0;
      ctrl.jump     = is_j & !ill;
      ctrl.jal      = is_j & op[3];
      ctrl.branch   = is_b & !ill;
      ctrl.alusrc1  = is_u;
      ctrl.alusrc2  = !(is_b | is_r);
      ctrl.regwrite = !(is_s | is_b | is_fence) & !ill;
      ctrl.memread  = is_load & !ill;
      ctrl.memwrite = is_s & !ill;
      ctrl.csr      = is_csr & !ill;
      ctrl.fence    = is_fence & !ill;
      ctrl.muldiv   = m_op & EN_M & !ill;
      ctrl.illegal  = ill;
      if (is_u)
         ctrl.im_sel = IM_U;
      else if (is_s)
         ctrl.im_sel = IM_S;
      else if (is_i | is_j | is_load)
         ctrl.im_sel = IM_I;
      else
         ctrl.im_sel = IM_NONE;
      ctrl.wr_sel = wr_sel_e'({is_csr | is_j | (is_u & op[5]), is_j | is_load | is_s});
      // Mul/div results come from the M unit, so the ALU function is parked at 0.
      if (is_u | is_j | is_s | ctrl.muldiv)
         ctrl.aluop = 4'b0000;
      else
         ctrl.aluop = {al3, al2, al1, al0};
      ctrl.md_op = ctrl.muldiv ? f3 : 3'b000;
      ctrl.rd    = instr[11:7];
      ctrl.rs1   = instr[19:15];
      ctrl.rs2   = instr[24:20];
   end
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decode/control stage between fetch and execute.
//  clk, reset : rising-edge clock, synchronous active-high reset
//  bus (slave): in_valid/in_ready/in_instr from fetch, flush, out_valid/out_ready and
//               the registered control bundle to execute, busy while a mul/div is in flight.
// One instruction is accepted per handshake and presented one cycle later. After a mul/div
// bundle is consumed, input stays blocked for MULDIV_LAT cycles (legal range 1..15).
module decode_ctrl_stage
   import decode_ctrl_stage_pkg::*;
#(
   parameter bit EN_M       = 1'b1,
   parameter bit EN_CSR     = 1'b1,
   parameter int MULDIV_LAT = 4,
   parameter int ALUOP_W    = 4
) (
   input logic               clk,
   input logic               reset,
   decode_ctrl_stage_if.slave bus
);
   localparam logic [3:0] MD_LOAD = 4'(MULDIV_LAT - 1);

   ctrl_bundle_t dec_p0;
   ctrl_bundle_t bundle_p1;
   logic         vld_p1;
   md_state_t    state;
   logic [3:0]   md_cnt;
   logic         busy_r;
   logic         in_ready;
   logic         accept;
   logic         consume;

   decode_comb #(.EN_M(EN_M), .EN_CSR(EN_CSR)) u_decode (
      .instr (bus.in_instr),
      .ctrl  (dec_p0)
   );

   assign in_ready = !reset && !bus.flush && (state == IDLE) && (!vld_p1 || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = vld_p1 && bus.out_ready;

   // p0 -> p1: decoded bundle registered on accept; FSM tracks the mul/div blocking window.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         bundle_p1 <= '0;
         state     <= IDLE;
         md_cnt    <= 4'd0;
         busy_r    <= 1'b0;
      end else begin
         if (bus.flush)
            vld_p1 <= 1'b0;
         else if (accept) begin
            vld_p1    <= 1'b1;
            bundle_p1 <= dec_p0;
         end else if (consume)
            vld_p1 <= 1'b0;

         unique case (state)
            IDLE: begin
               // Execute may sample during a flush, but the stage never starts the wait then.
               if (!bus.flush && consume && bundle_p1.muldiv) begin
                  state  <= MD_WAIT;
                  md_cnt <= MD_LOAD;
                  busy_r <= 1'b1;
               end
            end
            MD_WAIT: begin
               if (bus.flush || (md_cnt == 4'd0)) begin
                  state  <= IDLE;
                  md_cnt <= 4'd0;
                  busy_r <= 1'b0;
               end else
                  md_cnt <= md_cnt - 4'd1;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = vld_p1;
   assign bus.busy         = busy_r;
   assign bus.out_jump     = bundle_p1.jump;
   assign bus.out_jal      = bundle_p1.jal;
   assign bus.out_branch   = bundle_p1.branch;
   assign bus.out_alusrc1  = bundle_p1.alusrc1;
   assign bus.out_alusrc2  = bundle_p1.alusrc2;
   assign bus.out_regwrite = bundle_p1.regwrite;
   assign bus.out_memread  = bundle_p1.memread;
   assign bus.out_memwrite = bundle_p1.memwrite;
   assign bus.out_csr      = bundle_p1.csr;
   assign bus.out_fence    = bundle_p1.fence;
   assign bus.out_muldiv   = bundle_p1.muldiv;
   assign bus.out_illegal  = bundle_p1.illegal;
   assign bus.out_im_sel   = bundle_p1.im_sel;
   assign bus.out_wr_sel   = bundle_p1.wr_sel;
   assign bus.out_aluop    = ALUOP_W'(bundle_p1.aluop);
   assign bus.out_md_op    = bundle_p1.md_op;
   assign bus.out_rd       = bundle_p1.rd;
   assign bus.out_rs1      = bundle_p1.rs1;
   assign bus.out_rs2      = bundle_p1.rs2;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   decode_ctrl_stage_if #(.ALUOP_W(4)) bus ();
   decode_ctrl_stage_if #(.ALUOP_W(4)) nm_bus ();

   decode_ctrl_stage #(.EN_M(1'b1), .EN_CSR(1'b1), .MULDIV_LAT(LAT), .ALUOP_W(4)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   decode_ctrl_stage #(.EN_M(1'b0), .EN_CSR(1'b1), .MULDIV_LAT(LAT), .ALUOP_W(4)) dut_nm (
      .clk(clk), .reset(reset), .bus(nm_bus));

   // Bundle layout: flags[37:26] = jump,jal,branch,alusrc1,alusrc2,regwrite,memread,memwrite,
   // csr,fence,muldiv,illegal; im[25:24] wr[23:22] aluop[21:18] md[17:15] rd rs1 rs2.
   localparam int V_MD = 27;
   logic [37:0] dut_vec, nm_vec;
   assign dut_vec = {bus.out_jump, bus.out_jal, bus.out_branch, bus.out_alusrc1, bus.out_alusrc2,
                     bus.out_regwrite, bus.out_memread, bus.out_memwrite, bus.out_csr, bus.out_fence,
                     bus.out_muldiv, bus.out_illegal, bus.out_im_sel, bus.out_wr_sel, bus.out_aluop,
                     bus.out_md_op, bus.out_rd, bus.out_rs1, bus.out_rs2};
   assign nm_vec = {nm_bus.out_jump, nm_bus.out_jal, nm_bus.out_branch, nm_bus.out_alusrc1,
                    nm_bus.out_alusrc2, nm_bus.out_regwrite, nm_bus.out_memread, nm_bus.out_memwrite,
                    nm_bus.out_csr, nm_bus.out_fence, nm_bus.out_muldiv, nm_bus.out_illegal,
                    nm_bus.out_im_sel, nm_bus.out_wr_sel, nm_bus.out_aluop, nm_bus.out_md_op,
                    nm_bus.out_rd, nm_bus.out_rs1, nm_bus.out_rs2};

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [37:0] exp_pack(input logic [11:0] flags, input logic [1:0] im,
                                            input logic [1:0] wr, input logic [3:0] alu,
                                            input logic [2:0] md, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2);
      return {flags, im, wr, alu, md, rd, rs1, rs2};
   endfunction

   // Reference decoder: one entry per instruction kind, straight from the control rules.
   function automatic logic [37:0] model(input logic [31:0] w, input bit en_m, input bit en_csr);
      logic [6:0] op = w[6:0];
      logic [2:0] f = w[14:12];
      logic [6:0] f7 = w[31:25];
      bit jump = 0, jal = 0, br = 0, s1 = 0, s2 = 1, rw = 1, mr = 0, mw = 0;
      bit csr = 0, fen = 0, md = 0, ill = 0;
      logic [1:0] im = 2'd0, wr = 2'd0;
      logic [3:0] alu = 4'd0;
      logic [2:0] mdop = 3'd0;
      case (op)
         7'h6F: begin jump = 1; jal = 1; im = 2'd1; wr = 2'd3; end
         7'h67: begin jump = 1; im = 2'd1; wr = 2'd3; end
         7'h37: begin s1 = 1; im = 2'd3; wr = 2'd2; end
         7'h17: begin s1 = 1; im = 2'd3; end
         7'h63: begin br = 1; s2 = 0; rw = 0; alu = {2'b00, f[2], f[1]}; end
         7'h03: begin mr = 1; im = 2'd1; wr = 2'd1; if (f == 3'd4 || f == 3'd5) alu = 4'd3; end
         7'h23: begin mw = 1; rw = 0; im = 2'd2; wr = 2'd1; end
         7'h13: begin im = 2'd1; alu = {(f == 3'd5) & f7[5], f}; end
         7'h33: begin
            s2 = 0;
            if (f7 == 7'h01 && en_m) begin md = 1; mdop = f; end
            else begin alu = {f7[5], f}; ill = !(f7 == 7'h00 || f7 == 7'h20); end
         end
         7'h73: begin csr = 1; wr = 2'd2; alu = {2'b01, f[1], f[0]}; ill = !en_csr; end
         7'h0F: begin fen = 1; rw = 0; end
         default: ill = 1;
      endcase
      if (ill) begin jump = 0; br = 0; rw = 0; mr = 0; mw = 0; csr = 0; fen = 0; md = 0; end
      return {jump, jal, br, s1, s2, rw, mr, mw, csr, fen, md, ill, im, wr, alu, mdop,
              w[11:7], w[19:15], w[24:20]};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] op, f7;
      case ($urandom_range(0, 13))
         0: op = 7'h6F;  1: op = 7'h67;  2: op = 7'h37;  3: op = 7'h17;
         4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
         8, 9: op = 7'h33; 10: op = 7'h73; 11: op = 7'h0F;
         default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
         0, 1: f7 = 7'h00;
         2: f7 = 7'h20;
         3: f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
   endfunction

   // Scoreboard: accepted instructions are pushed with their predicted bundle.
   logic [37:0] exp_q[$];
   bit          acc_pending = 0;
   logic [37:0] acc_vec;
   int          md_left = 0;

   always @(negedge clk) begin
      acc_pending = bus.in_valid && bus.in_ready;
      acc_vec = model(bus.in_instr, 1'b1, 1'b1);
   end

   always @(posedge clk) begin
      if (reset) exp_q.delete();
      else if (acc_pending) exp_q.push_back(acc_vec);
      acc_pending = 0;
   end

   // Monitor: compares presented bundle and handshake state against the model every cycle.
   always @(negedge clk) begin
      bit          exp_valid, exp_rdy, consume;
      logic [37:0] front;
      exp_valid = (exp_q.size() != 0);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("busy", bus.busy, md_left != 0);
      exp_rdy = !reset && !bus.flush && (md_left == 0) && (!exp_valid || bus.out_ready);
      chk("in_ready", bus.in_ready, exp_rdy);
      front = exp_valid ? exp_q[0] : '0;
      if (exp_valid && bus.out_valid) chk("bundle", dut_vec, front);
      consume = exp_valid && bus.out_ready && !reset;
      if (reset || bus.flush) md_left = 0;
      else if (md_left > 0) md_left = md_left - 1;
      else if (consume && front[V_MD]) md_left = LAT;
      if (!reset) begin
         if (consume) void'(exp_q.pop_front());
         else if (bus.flush && exp_valid) void'(exp_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] w);
      bit ok = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1;
      end
      chk("drive_accept", ok, 1);
      step();
      bus.in_valid = 1'b0;
   endtask

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_LBU  = 32'h0000C183;
   localparam logic [31:0] I_MUL  = 32'h022081B3;
   localparam logic [31:0] I_ADD5 = 32'h007302B3;

   initial begin
      int cnt;
      bit seen;
      bus.in_valid = 0; bus.in_instr = 0; bus.flush = 0; bus.out_ready = 1;
      nm_bus.in_valid = 0; nm_bus.in_instr = 0; nm_bus.flush = 0; nm_bus.out_ready = 1;

      // Reset state
      @(negedge clk);
      chk("reset_vec", dut_vec, 38'd0);
      chk("reset_in_ready", bus.in_ready, 0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", bus.in_ready, 1);
      step();

      // Basic decodes
      drive(I_ADD);
      @(negedge clk);
      chk("add", dut_vec, exp_pack(12'b000001000000, 2'b00, 2'b00, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2));
      step();
      drive(I_SUB);
      @(negedge clk);
      chk("sub", dut_vec, exp_pack(12'b000001000000, 2'b00, 2'b00, 4'b1000, 3'd0, 5'd3, 5'd1, 5'd2));
      step();
      drive(I_LW);
      @(negedge clk);
      chk("lw_memread", bus.out_memread, 1);
      chk("lw_im_sel", bus.out_im_sel, 2'b01);
      chk("lw_wr_sel", bus.out_wr_sel, 2'b01);
      step();
      drive(I_LBU);
      @(negedge clk);
      chk("lbu", dut_vec, exp_pack(12'b000011100000, 2'b01, 2'b01, 4'b0011, 3'd0, 5'd3, 5'd1, 5'd0));
      step();

      // Mul/div issue and blocking window
      drive(I_MUL);
      @(negedge clk);
      chk("mul", dut_vec, exp_pack(12'b000001000010, 2'b00, 2'b00, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2));
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy) cnt++;
         else if (cnt > 0) break;
      end
      chk("md_busy_cycles", cnt, LAT);
      step();

      // Same word with M disabled
      nm_bus.in_valid = 1'b1;
      nm_bus.in_instr = I_MUL;
      @(negedge clk);
      chk("nm_in_ready", nm_bus.in_ready, 1);
      step();
      nm_bus.in_valid = 1'b0;
      @(negedge clk);
      chk("nm_mul_illegal", nm_vec, exp_pack(12'b000000000001, 2'b00, 2'b00, 4'b0000, 3'd0, 5'd3, 5'd1, 5'd2));
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (nm_bus.busy) seen = 1;
      end
      chk("nm_no_busy", seen, 0);
      step();

      // Backpressure: bundle held, new input stalled
      bus.out_ready = 1'b0;
      drive(I_ADD5);
      bus.in_valid = 1'b1;
      bus.in_instr = I_SUB;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_hold", dut_vec, exp_pack(12'b000001000000, 2'b00, 2'b00, 4'b0000, 3'd0, 5'd5, 5'd6, 5'd7));
      end
      step();
      bus.out_ready = 1'b1;
      drive(I_SUB);

      // Full-throughput stream
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom),
                         3'($urandom), 5'($urandom), ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13};
         @(negedge clk);
         chk("stream_in_ready", bus.in_ready, 1);
         if (i > 0) chk("stream_out_valid", bus.out_valid, 1);
         step();
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("stream_last_valid", bus.out_valid, 1);
      step();
      step();

      // Flush on the second MD_WAIT cycle
      drive(I_MUL);
      step();
      step();
      bus.flush = 1'b1;
      @(negedge clk);
      chk("flush_pre_busy", bus.busy, 1);
      step();
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", bus.busy, 0);
      chk("flush_out_valid", bus.out_valid, 0);
      chk("flush_in_ready", bus.in_ready, 1);
      step();

      // Reset while held under backpressure
      bus.out_ready = 1'b0;
      drive(I_ADD);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_mid_vec", dut_vec, 38'd0);
      chk("reset_mid_valid", bus.out_valid, 0);
      step();
      bus.out_ready = 1'b1;
      drive(32'h00000000);
      @(negedge clk);
      chk("zero_illegal", dut_vec, exp_pack(12'b000010000001, 2'b00, 2'b00, 4'b0000, 3'd0, 5'd0, 5'd0, 5'd0));
      step();

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         bus.flush = ($urandom_range(0, 29) == 0);
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.in_instr = rand_instr();
         bus.out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      reset = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      repeat (25) step();
      chk("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
